gpu_dmem_banked: RTL

Multi-lane, multi-bank GPU shared data memory serving one warp-wide vector request at a time. Each lane's word address is interleaved across `NUM_BANKS` synchronous single-port banks. Bank conflicts are serialised into multiple passes, and same-word reads are broadcast in one pass. It sits between the GPU SIMT load/store unit and on-chip data storage, and replaces the fixed two-port data memory with a width-, depth- and lane-parametrised array.

---
 rtl/gpu_dmem_banked_pkg.sv | 18 +
 rtl/gpu_dmem_bank.sv | 32 +++
 rtl/gpu_dmem_banked.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gpu_dmem_banked_pkg.sv
// Shared definitions for the banked GPU data memory: FSM states, conflict counter width
// and the saturating counter step.
package gpu_dmem_banked_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int CNT_W = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/gpu_dmem_bank.sv
// One synchronous single-port RAM bank with registered read data and byte-granular writes.
module gpu_dmem_bank #(
   parameter int ROW_W      = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                    i_clk,
   input  logic                    i_en,
   input  logic                    i_we,
   input  logic [ROW_W-1:0]        i_row,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_be,
   output logic [DATA_WIDTH-1:0]   o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [0:2**ROW_W-1];
   logic [DATA_WIDTH-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
               if (i_be[b]) r_mem[i_row][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end else begin
            r_rdata <= r_mem[i_row];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/gpu_dmem_banked.sv
// Banked multi-lane shared data memory: one vector request at a time, bank conflicts serialised
// into passes, same-word reads broadcast. GPU_DMEM_BYTE_WE_EN adds req_be byte-enabled writes.
module gpu_dmem_banked
   import gpu_dmem_banked_pkg::*;
#(
   parameter int NUM_LANES  = 4,
   parameter int NUM_BANKS  = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic                              req_we,
   input  logic [NUM_LANES-1:0]              req_mask,
   input  logic [NUM_LANES*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_LANES*DATA_WIDTH-1:0]   req_wdata,
`ifdef GPU_DMEM_BYTE_WE_EN
   input  logic [NUM_LANES*DATA_WIDTH/8-1:0] req_be,
`endif
   output logic                              resp_valid,
   input  logic                              resp_ready,
   output logic [NUM_LANES*DATA_WIDTH-1:0]   resp_rdata,
   output logic [15:0]                       conflict_cnt
);

   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int ROW_W  = ADDR_WIDTH - BANK_W;
   localparam int BE_W   = DATA_WIDTH / 8;

   state_t                r_state;
   logic [NUM_LANES-1:0]  r_pend, r_rd_gnt, w_grant, w_pend_next;
   logic                  r_we, r_first, r_resp_valid, w_accept;
   logic [CNT_W-1:0]      r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr  [NUM_LANES];
   logic [DATA_WIDTH-1:0] r_wdata [NUM_LANES];
   logic [DATA_WIDTH-1:0] r_rdata [NUM_LANES];
   logic [BE_W-1:0]       r_be    [NUM_LANES];
   logic [BANK_W-1:0]     w_lane_bank [NUM_LANES];
   logic [ROW_W-1:0]      w_lane_row  [NUM_LANES];

   logic                  w_bank_en    [NUM_BANKS];
   logic                  w_bank_we    [NUM_BANKS];
   logic [ROW_W-1:0]      w_bank_row   [NUM_BANKS];
   logic [DATA_WIDTH-1:0] w_bank_wdata [NUM_BANKS];
   logic [BE_W-1:0]       w_bank_be    [NUM_BANKS];
   logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];

   assign req_ready    = (r_state == ST_IDLE) && !rst;
   assign w_accept     = req_ready && req_valid;
   assign w_pend_next  = r_pend & ~w_grant;
   assign resp_valid   = r_resp_valid;
   assign conflict_cnt = r_cnt;

   always_comb begin
      resp_rdata = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         w_lane_bank[l] = r_addr[l][BANK_W-1:0];
         w_lane_row[l]  = r_addr[l][ADDR_WIDTH-1:BANK_W];
         resp_rdata[l*DATA_WIDTH +: DATA_WIDTH] = r_rdata[l];
      end
   end

   // Per bank the lowest pending lane leads; reads also take every pending lane on the same word.
   always_comb begin
      logic                  found;
      logic [ADDR_WIDTH-1:0] lead;
      w_grant = '0;
      found   = 1'b0;
      lead    = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         found           = 1'b0;
         lead            = '0;
         w_bank_en[b]    = 1'b0;
         w_bank_we[b]    = 1'b0;
         w_bank_row[b]   = '0;
         w_bank_wdata[b] = '0;
         w_bank_be[b]    = '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            if (r_pend[l] && (w_lane_bank[l] == BANK_W'(b))) begin
               if (!found) begin
                  found           = 1'b1;
                  lead            = r_addr[l];
                  w_grant[l]      = 1'b1;
                  w_bank_en[b]    = (r_state == ST_SERVE);
                  w_bank_we[b]    = r_we;
                  w_bank_row[b]   = w_lane_row[l];
                  w_bank_wdata[b] = r_wdata[l];
                  w_bank_be[b]    = r_be[l];
               end else if (!r_we && (r_addr[l] == lead)) begin
                  w_grant[l] = 1'b1;
               end
            end
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      gpu_dmem_bank #(
         .ROW_W      (ROW_W),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
         .i_clk   (clk),
         .i_en    (w_bank_en[b]),
         .i_we    (w_bank_we[b]),
         .i_row   (w_bank_row[b]),
         .i_wdata (w_bank_wdata[b]),
         .i_be    (w_bank_be[b]),
         .o_rdata (w_bank_rdata[b])
      );
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we <= req_we;
         for (int l = 0; l < NUM_LANES; l++) begin
            r_addr[l]  <= req_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata[l] <= req_wdata[l*DATA_WIDTH +: DATA_WIDTH];
`ifdef GPU_DMEM_BYTE_WE_EN
            r_be[l]    <= req_be[l*BE_W +: BE_W];
`else
            r_be[l]    <= '1;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_pend       <= '0;
         r_rd_gnt     <= '0;
         r_first      <= 1'b0;
         r_resp_valid <= 1'b0;
         r_cnt        <= '0;
         for (int l = 0; l < NUM_LANES; l++) r_rdata[l] <= '0;
      end else begin
         // Bank data from the previous read pass is valid this cycle.
         for (int l = 0; l < NUM_LANES; l++) begin
            if (r_rd_gnt[l]) r_rdata[l] <= w_bank_rdata[w_lane_bank[l]];
         end
         r_rd_gnt <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_pend  <= req_mask;
                  r_first <= 1'b1;
                  for (int l = 0; l < NUM_LANES; l++) r_rdata[l] <= '0;
                  r_state <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               r_pend   <= w_pend_next;
               r_rd_gnt <= r_we ? '0 : w_grant;
               r_first  <= 1'b0;
               if (!r_first) r_cnt <= sat_inc(r_cnt);
               if (w_pend_next == '0) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               r_resp_valid <= 1'b1;
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
